// File: rtl/ctrl_hazard_stage_pkg.sv
// rtl/ctrl_hazard_stage_pkg.sv - shared constants and state type for the ID/EX hazard stage
package ctrl_hazard_stage_pkg;

    localparam int NBITS_DEF = 11;
    localparam int REG_W_DEF = 5;
    localparam int SQ_W      = 4;

    // Control-word layout: {Branch,Jal,Jalr,MemRead,MemWrite,MemToReg,RegWrite,AluSrc,ALUOp[2:0]}
    localparam int BRANCH_B   = 10;
    localparam int JAL_B      = 9;
    localparam int JALR_B     = 8;
    localparam int MEMREAD_B  = 7;
    localparam int MEMWRITE_B = 6;
    localparam int MEMTOREG_B = 5;
    localparam int REGWRITE_B = 4;
    localparam int ALUSRC_B   = 3;
    localparam int ALUOP_MSB  = 2;
    localparam int ALUOP_LSB  = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_hazard_stage_if.sv
// rtl/ctrl_hazard_stage_if.sv - ID-side inputs and EX-side outputs of the hazard stage
interface ctrl_hazard_stage_if #(
    parameter int NBITS = 11,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [NBITS-1:0] ctrl_i;
    logic             valid_i;
    logic [REG_W-1:0] rs1_i;
    logic [REG_W-1:0] rs2_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             flush_i;
    logic             hold_i;
    logic [NBITS-1:0] ctrl_o;
    logic             valid_o;
    logic             bubble_o;
    logic             stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport slave (
        input  ctrl_i, valid_i, rs1_i, rs2_i, ex_memread_i, ex_rd_i, flush_i, hold_i,
        output ctrl_o, valid_o, bubble_o, stall_o, bubble_cnt_o
    );

    modport master (
        output ctrl_i, valid_i, rs1_i, rs2_i, ex_memread_i, ex_rd_i, flush_i, hold_i,
        input  ctrl_o, valid_o, bubble_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/ctrl_hazard_stage_hazard_detect_unit.sv
// rtl/ctrl_hazard_stage_hazard_detect_unit.sv - combinational load-use compare between EX and ID
module hazard_detect_unit #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_memread,
    input  logic             i_ex_valid,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    output logic             o_load_use
);
    logic w_rd_nonzero;
    logic w_rs_match;

    // x0 is hardwired zero, so a load into it never creates a dependency
    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_rs_match   = (i_ex_rd == i_rs1) | (i_ex_rd == i_rs2);
    assign o_load_use   = i_ex_memread & i_ex_valid & w_rd_nonzero & w_rs_match & i_id_valid;
endmodule

// File: rtl/ctrl_hazard_stage.sv
// rtl/ctrl_hazard_stage.sv - registered ID/EX control word with load-use bubbles, flush squash and bubble counter
module ctrl_hazard_stage
    import ctrl_hazard_stage_pkg::*;
#(
    parameter int NBITS        = NBITS_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    ctrl_hazard_stage_if.slave bus
);
    localparam logic [SQ_W-1:0] SQ_INIT     = SQ_W'(FLUSH_CYCLES - 1);
    localparam state_t          FLUSH_STATE = (FLUSH_CYCLES > 1) ? ST_SQUASH : ST_RUN;

    state_t            r_state;
    logic [SQ_W-1:0]   r_sq_cnt;
    logic [NBITS-1:0]  r_ctrl;
    logic              r_valid;
    logic              r_bubble;
    logic [CNT_W-1:0]  r_cnt;

    state_t            w_state_next;
    logic [SQ_W-1:0]   w_sq_next;
    logic [NBITS-1:0]  w_ctrl_next;
    logic              w_valid_next;
    logic              w_bubble_next;
    logic              w_inject;
    logic              w_load_use;

    hazard_detect_unit #(.REG_W(REG_W)) u_hdu (
        .i_ex_memread (bus.ex_memread_i),
        .i_ex_valid   (r_valid),
        .i_ex_rd      (bus.ex_rd_i),
        .i_id_valid   (bus.valid_i),
        .i_rs1        (bus.rs1_i),
        .i_rs2        (bus.rs2_i),
        .o_load_use   (w_load_use)
    );

    always_comb begin
        w_state_next  = r_state;
        w_sq_next     = r_sq_cnt;
        w_ctrl_next   = r_ctrl;
        w_valid_next  = r_valid;
        w_bubble_next = r_bubble;
        w_inject      = 1'b0;

        if (bus.flush_i) begin
            w_inject     = 1'b1;
            w_state_next = FLUSH_STATE;
            w_sq_next    = (FLUSH_CYCLES > 1) ? SQ_INIT : '0;
        end else begin
            case (r_state)
                ST_SQUASH: begin
                    // hold_i is deliberately ignored here so a freeze cannot stretch the squash
                    w_inject  = 1'b1;
                    w_sq_next = r_sq_cnt - 1'b1;
                    if (r_sq_cnt == SQ_W'(1)) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    if (bus.hold_i) begin
                        w_inject = 1'b0;
                    end else if (w_load_use) begin
                        w_inject = 1'b1;
                    end else begin
                        w_ctrl_next   = bus.ctrl_i;
                        w_valid_next  = bus.valid_i;
                        w_bubble_next = 1'b0;
                    end
                end
            endcase
        end

        if (w_inject) begin
            w_ctrl_next   = '0;
            w_valid_next  = 1'b0;
            w_bubble_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= '0;
            r_ctrl   <= '0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_sq_cnt <= w_sq_next;
            r_ctrl   <= w_ctrl_next;
            r_valid  <= w_valid_next;
            r_bubble <= w_bubble_next;
            if (w_inject && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Hold always freezes the front end, even when a flush overrides the stage update
    assign bus.stall_o      = bus.hold_i | (w_load_use & (r_state == ST_RUN) & ~bus.flush_i);
    assign bus.ctrl_o       = r_ctrl;
    assign bus.valid_o      = r_valid;
    assign bus.bubble_o     = r_bubble;
    assign bus.bubble_cnt_o = r_cnt;
endmodule

// File: tb/tb_ctrl_hazard_stage.sv
// tb/tb_ctrl_hazard_stage.sv - self-checking bench for ctrl_hazard_stage (FLUSH_CYCLES=3 and CNT_W=2 instances)
module tb_ctrl_hazard_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] t_ctrl;
    logic        t_valid;
    logic [4:0]  t_rs1, t_rs2, t_exrd;
    logic        t_memread, t_flush, t_hold;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_hazard_stage_if #(.NBITS(11), .REG_W(5), .CNT_W(16)) if_a ();
    ctrl_hazard_stage_if #(.NBITS(11), .REG_W(5), .CNT_W(2))  if_b ();

    assign if_a.ctrl_i       = t_ctrl;
    assign if_a.valid_i      = t_valid;
    assign if_a.rs1_i        = t_rs1;
    assign if_a.rs2_i        = t_rs2;
    assign if_a.ex_memread_i = t_memread;
    assign if_a.ex_rd_i      = t_exrd;
    assign if_a.flush_i      = t_flush;
    assign if_a.hold_i       = t_hold;
    assign if_b.ctrl_i       = t_ctrl;
    assign if_b.valid_i      = t_valid;
    assign if_b.rs1_i        = t_rs1;
    assign if_b.rs2_i        = t_rs2;
    assign if_b.ex_memread_i = t_memread;
    assign if_b.ex_rd_i      = t_exrd;
    assign if_b.flush_i      = t_flush;
    assign if_b.hold_i       = t_hold;

    ctrl_hazard_stage #(.NBITS(11), .REG_W(5), .FLUSH_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    ctrl_hazard_stage #(.NBITS(11), .REG_W(5), .FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    // Reference model: index 0 = dut_a, 1 = dut_b
    int m_ctrl[2], m_valid[2], m_bubble[2], m_cnt[2], m_left[2];
    int m_flush[2] = '{3, 1};
    int m_max[2]   = '{65535, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_ctrl[d] = 0; m_valid[d] = 0; m_bubble[d] = 0; m_cnt[d] = 0; m_left[d] = 0;
        end
    endtask

    function automatic bit m_load_use(int d);
        return t_memread && (m_valid[d] != 0) && (t_exrd != 0) &&
               ((t_exrd == t_rs1) || (t_exrd == t_rs2)) && t_valid;
    endfunction

    function automatic bit m_stall(int d);
        return t_hold || (m_load_use(d) && (m_left[d] == 0) && !t_flush);
    endfunction

    task automatic m_step();
        for (int d = 0; d < 2; d++) begin
            bit inject = 0;
            bit lu = m_load_use(d);
            if (t_flush) begin
                inject = 1; m_left[d] = m_flush[d] - 1;
            end else if (m_left[d] > 0) begin
                inject = 1; m_left[d]--;
            end else if (t_hold) begin
                inject = 0;
            end else if (lu) begin
                inject = 1;
            end else begin
                m_ctrl[d] = t_ctrl; m_valid[d] = t_valid; m_bubble[d] = 0;
            end
            if (inject) begin
                m_ctrl[d] = 0; m_valid[d] = 0; m_bubble[d] = 1;
                if (m_cnt[d] < m_max[d]) m_cnt[d]++;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, " a.ctrl"},   32'(if_a.ctrl_o),       32'(m_ctrl[0]));
        chk({tag, " a.valid"},  32'(if_a.valid_o),      32'(m_valid[0]));
        chk({tag, " a.bubble"}, 32'(if_a.bubble_o),     32'(m_bubble[0]));
        chk({tag, " a.cnt"},    32'(if_a.bubble_cnt_o), 32'(m_cnt[0]));
        chk({tag, " b.ctrl"},   32'(if_b.ctrl_o),       32'(m_ctrl[1]));
        chk({tag, " b.valid"},  32'(if_b.valid_o),      32'(m_valid[1]));
        chk({tag, " b.bubble"}, 32'(if_b.bubble_o),     32'(m_bubble[1]));
        chk({tag, " b.cnt"},    32'(if_b.bubble_cnt_o), 32'(m_cnt[1]));
    endtask

    task automatic pre(input string tag);
        #1;
        chk({tag, " a.stall"}, 32'(if_a.stall_o), 32'(m_stall(0)));
        chk({tag, " b.stall"}, 32'(if_b.stall_o), 32'(m_stall(1)));
    endtask

    task automatic post(input string tag);
        @(posedge clk);
        m_step();
        #1;
        check_outs(tag);
    endtask

    task automatic set_in(input bit fl, input bit hd, input bit vl, input bit mr,
                          input logic [10:0] c, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd);
        t_flush = fl; t_hold = hd; t_valid = vl; t_memread = mr;
        t_ctrl = c; t_rs1 = r1; t_rs2 = r2; t_exrd = rd;
    endtask

    task automatic do_reset(input string tag);
        #3;
        reset = 1'b0;
        m_reset();
        #1;
        check_outs(tag);
        #2;
        reset = 1'b1;
    endtask

    typedef struct {
        bit          flush, hold, valid, memread;
        logic [10:0] ctrl;
        logic [4:0]  rs1, rs2, exrd;
        bit          e_stall;
        logic [10:0] e_ctrl;
        bit          e_valid, e_bubble;
        int          e_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{0,0,1,0,11'h0A5,5'd1,5'd2,5'd0, 0,11'h0A5,1,0,0};
        tbl[1]  = '{0,0,1,1,11'h123,5'd1,5'd5,5'd5, 1,11'h000,0,1,1};
        tbl[2]  = '{0,0,1,1,11'h123,5'd1,5'd5,5'd5, 0,11'h123,1,0,1};
        tbl[3]  = '{0,0,1,1,11'h0F0,5'd0,5'd0,5'd0, 0,11'h0F0,1,0,1};
        tbl[4]  = '{1,0,1,1,11'h7FF,5'd7,5'd2,5'd7, 0,11'h000,0,1,2};
        tbl[5]  = '{0,1,1,0,11'h111,5'd0,5'd0,5'd0, 1,11'h000,0,1,3};
        tbl[6]  = '{0,1,1,0,11'h111,5'd0,5'd0,5'd0, 1,11'h000,0,1,4};
        tbl[7]  = '{0,0,1,0,11'h222,5'd0,5'd0,5'd0, 0,11'h222,1,0,4};
        tbl[8]  = '{1,1,1,0,11'h222,5'd0,5'd0,5'd0, 1,11'h000,0,1,5};
        tbl[9]  = '{0,0,1,0,11'h333,5'd0,5'd0,5'd0, 0,11'h000,0,1,6};
        tbl[10] = '{0,0,1,0,11'h333,5'd0,5'd0,5'd0, 0,11'h000,0,1,7};
        tbl[11] = '{0,0,1,0,11'h333,5'd0,5'd0,5'd0, 0,11'h333,1,0,7};
        for (int i = 12; i < 16; i++)
            tbl[i] = '{0,1,1,1,11'(11'h400 + i - 12),5'd3,5'd1,5'd3, 1,11'h333,1,0,7};
        tbl[16] = '{0,0,1,0,11'h404,5'd0,5'd0,5'd0, 0,11'h404,1,0,7};

        set_in(0, 0, 0, 0, 11'h0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        m_reset();
        #3;
        check_outs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].flush, tbl[i].hold, tbl[i].valid, tbl[i].memread,
                   tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].exrd);
            pre($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d stall", i), 32'(if_a.stall_o), 32'(tbl[i].e_stall));
            post($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d ctrl", i),   32'(if_a.ctrl_o),       32'(tbl[i].e_ctrl));
            chk($sformatf("tbl%0d valid", i),  32'(if_a.valid_o),      32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d bubble", i), 32'(if_a.bubble_o),     32'(tbl[i].e_bubble));
            chk($sformatf("tbl%0d cnt", i),    32'(if_a.bubble_cnt_o), 32'(tbl[i].e_cnt));
        end

        // Reset landing in the middle of a squash must return straight to RUN
        set_in(1, 0, 1, 0, 11'h155, 5'd0, 5'd0, 5'd0);
        pre("sqrst flush");
        post("sqrst flush");
        set_in(0, 0, 1, 0, 11'h155, 5'd0, 5'd0, 5'd0);
        do_reset("sqrst mid");
        set_in(0, 0, 1, 0, 11'h0A5, 5'd0, 5'd0, 5'd0);
        pre("sqrst rel");
        post("sqrst rel");
        chk("sqrst ctrl passes", 32'(if_a.ctrl_o), 32'h0A5);
        chk("sqrst no bubble", 32'(if_a.bubble_o), 32'h0);

        // A held load-use pattern bubbles every other cycle; 6 bubbles saturate the 2-bit counter
        do_reset("sat reset");
        set_in(0, 0, 1, 1, 11'h055, 5'd1, 5'd5, 5'd5);
        for (int i = 0; i < 12; i++) begin
            pre($sformatf("sat%0d", i));
            post($sformatf("sat%0d", i));
            chk($sformatf("sat%0d b.cnt", i), 32'(if_b.bubble_cnt_o),
                32'(((i + 1) / 2 > 3) ? 3 : (i + 1) / 2));
        end
        chk("sat a.cnt", 32'(if_a.bubble_cnt_o), 32'd6);

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                   $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                   11'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)));
            pre($sformatf("rnd%0d", i));
            post($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
